// File: rtl/bp_be_stride_prefetch_issuer.sv
// bp_be_stride_prefetch_issuer: stride table that turns confirmed strides into up to degree_p
// page-bounded prefetch requests, fed by a 2-entry event FIFO that drops on overflow.
package bp_be_stride_prefetch_pkg;
  typedef enum logic [3:0] {e_bp_default_cfg = 4'd0} bp_params_e;
  function automatic int proc_vaddr_width(bp_params_e cfg);
    case (cfg)
      default: return 39;
    endcase
  endfunction
endpackage

module bp_be_stride_prefetch_issuer
  import bp_be_stride_prefetch_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int stride_width_p = 8,
  parameter int streams_p = 4,
  parameter int degree_p = 2,
  localparam int vaddr_width_p = proc_vaddr_width(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  input  logic [vaddr_width_p-1:0]  striding_pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_and_i,
  output logic                      drop_o
);
  localparam int idx_w = streams_p > 1 ? $clog2(streams_p) : 1;
  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE} state_e;
  typedef struct packed {
    logic                      conf;
    logic [vaddr_width_p-1:0]  pc;
    logic [vaddr_width_p-1:0]  eff;
    logic [stride_width_p-1:0] stride;
  } event_s;
  typedef struct packed {
    logic                      v;
    logic                      active;
    logic [vaddr_width_p-1:0]  pc;
    logic [stride_width_p-1:0] stride;
    logic [vaddr_width_p-1:0]  last;
  } entry_s;

  state_e state_q, state_d;
  event_s fifo_q [2];
  event_s fifo_d [2];
  event_s ev_q, ev_d, ev_in;
  entry_s tbl_q [streams_p];
  entry_s tbl_d [streams_p];
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic [idx_w-1:0] vic_q, vic_d, idx_q, idx_d, hit_idx, free_idx, sel;
  logic [2:0] k_q, k_d;
  logic pf_v_q, pf_v_d, drop_q, drop_d;
  logic [vaddr_width_p-1:0] pf_addr_q, pf_addr_d, stride_sx, cand, cand_nxt;
  logic evt, pop, push, hit, free, pg_cand, pg_nxt, dup;

  assign evt = start_discovery_i | confirm_discovery_i;
  assign ev_in = {confirm_discovery_i, striding_pc_i, eff_addr_i, stride_i};
  assign pop = state_q == IDLE && cnt_q != 2'd0;
  assign push = evt && (cnt_q != 2'd2 || pop);
  assign stride_sx = vaddr_width_p'($signed(ev_q.stride));
  assign cand = ev_q.eff + vaddr_width_p'(k_q) * stride_sx;
  assign cand_nxt = cand + stride_sx;
  assign pg_cand = cand[vaddr_width_p-1:12] == ev_q.eff[vaddr_width_p-1:12];
  assign pg_nxt = cand_nxt[vaddr_width_p-1:12] == ev_q.eff[vaddr_width_p-1:12];

  // Descending scan so the lowest-numbered match/free slot wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free = 1'b0;
    free_idx = '0;
    for (int i = streams_p - 1; i >= 0; i--) begin
      if (tbl_q[i].v && tbl_q[i].pc == ev_q.pc) begin
        hit = 1'b1;
        hit_idx = idx_w'(i);
      end
      if (!tbl_q[i].v) begin
        free = 1'b1;
        free_idx = idx_w'(i);
      end
    end
  end

  assign sel = hit ? hit_idx : free ? free_idx : vic_q;
  assign dup = hit && tbl_q[sel].active && tbl_q[sel].last == ev_q.eff;

  always_comb begin
    state_d = state_q;
    fifo_d = fifo_q;
    wr_d = wr_q;
    rd_d = rd_q;
    ev_d = ev_q;
    tbl_d = tbl_q;
    vic_d = vic_q;
    idx_d = idx_q;
    k_d = k_q;
    pf_v_d = pf_v_q;
    pf_addr_d = pf_addr_q;
    drop_d = evt && !push;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    if (push) begin
      fifo_d[wr_q] = ev_in;
      wr_d = ~wr_q;
    end
    if (pop) begin
      ev_d = fifo_q[rd_q];
      rd_d = ~rd_q;
      state_d = LOOKUP;
    end
    case (state_q)
      LOOKUP: begin
        idx_d = sel;
        k_d = 3'd1;
        vic_d = (hit || free) ? vic_q : (vic_q == idx_w'(streams_p - 1)) ? '0 : vic_q + idx_w'(1);
        tbl_d[sel].v = 1'b1;
        tbl_d[sel].pc = ev_q.pc;
        tbl_d[sel].stride = ev_q.stride;
        tbl_d[sel].active = ev_q.conf;
        tbl_d[sel].last = (ev_q.conf && hit) ? tbl_q[sel].last : ev_q.eff;
        state_d = (ev_q.conf && ev_q.stride != '0 && !dup) ? ISSUE : IDLE;
      end
      // First ISSUE cycle loads the k=1 candidate; each transfer loads the next one.
      ISSUE: begin
        if (!pf_v_q) begin
          pf_v_d = pg_cand;
          pf_addr_d = pg_cand ? cand : pf_addr_q;
          state_d = pg_cand ? ISSUE : IDLE;
        end else if (pf_ready_and_i) begin
          tbl_d[idx_q].last = pf_addr_q;
          k_d = k_q + 3'd1;
          pf_v_d = k_q != 3'(degree_p) && pg_nxt;
          pf_addr_d = pf_v_d ? cand_nxt : pf_addr_q;
          state_d = pf_v_d ? ISSUE : IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      fifo_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
      ev_q <= '0;
      tbl_q <= '{default: '0};
      vic_q <= '0;
      idx_q <= '0;
      k_q <= 3'd0;
      pf_v_q <= 1'b0;
      pf_addr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fifo_q <= fifo_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ev_q <= ev_d;
      tbl_q <= tbl_d;
      vic_q <= vic_d;
      idx_q <= idx_d;
      k_q <= k_d;
      pf_v_q <= pf_v_d;
      pf_addr_q <= pf_addr_d;
      drop_q <= drop_d;
    end
  end

  assign pf_v_o = pf_v_q;
  assign pf_addr_o = pf_addr_q;
  assign drop_o = drop_q;
endmodule

// File: tb/tb_bp_be_stride_prefetch_issuer.sv
// tb_bp_be_stride_prefetch_issuer: directed and random checks against a transaction-level
// model of the stream table and its expected prefetch stream.
module tb_bp_be_stride_prefetch_issuer;
  localparam int VA = 39;
  localparam int DEG = 2;
  localparam int NS = 4;
  localparam longint MASK = (64'sd1 <<< VA) - 1;

  logic clk = 1'b0, reset_n_i = 1'b0, start_i = 1'b0, conf_i = 1'b0, ready = 1'b1;
  logic [VA-1:0] pc_i = '0, eff_i = '0;
  logic [7:0] st_i = '0;
  logic pf_v, drop;
  logic [VA-1:0] pf_addr;
  int compared = 0, mismatched = 0;
  longint exp_q[$];
  bit drop_arm = 1'b0;
  bit m_v[NS], m_act[NS];
  longint m_pc[NS], m_last[NS];
  int vic;

  always #5 clk = ~clk;

  bp_be_stride_prefetch_issuer #(.stride_width_p(8), .streams_p(NS), .degree_p(DEG)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_discovery_i(start_i), .confirm_discovery_i(conf_i),
    .striding_pc_i(pc_i), .eff_addr_i(eff_i), .stride_i(st_i), .pf_v_o(pf_v), .pf_addr_o(pf_addr),
    .pf_ready_and_i(ready), .drop_o(drop));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_v[i] = 0;
      m_act[i] = 0;
      m_pc[i] = 0;
      m_last[i] = 0;
    end
    vic = 0;
    exp_q.delete();
  endfunction

  // Whole-event semantics: look up / allocate, then list every prefetch this event should produce.
  function automatic void model_event(bit c, logic [VA-1:0] pc, logic [VA-1:0] eff, logic [7:0] st);
    int e = -1;
    bit hit = 0, sup;
    longint sx = longint'($signed(st));
    longint base = longint'(eff);
    longint a;
    for (int i = 0; i < NS; i++)
      if (!hit && m_v[i] && m_pc[i] == longint'(pc)) begin hit = 1; e = i; end
    if (!hit) begin
      for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) e = i;
      if (e < 0) begin e = vic; vic = (vic + 1) % NS; end
    end
    sup = st == 0 || (hit && m_act[e] && m_last[e] == base);
    m_v[e] = 1;
    m_pc[e] = longint'(pc);
    if (!c || !hit) m_last[e] = base;
    m_act[e] = c;
    if (c && !sup)
      for (int k = 1; k <= DEG; k++) begin
        a = (base + k * sx) & MASK;
        if ((a >> 12) != (base >> 12)) break;
        exp_q.push_back(a);
        m_last[e] = a;
      end
  endfunction

  task automatic tick();
    bit x, dexp;
    logic [63:0] a;
    x = pf_v === 1'b1 && ready === 1'b1;
    a = 64'(pf_addr);
    dexp = drop_arm;
    drop_arm = 0;
    @(posedge clk);
    #1;
    chk("drop_o", 64'(drop), 64'(dexp));
    if (x) begin
      chk("pf_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("pf_xfer_addr", a, 64'(exp_q.pop_front()));
    end
  endtask

  task automatic evt(bit s, bit c, logic [VA-1:0] pc, logic [VA-1:0] eff, logic [7:0] st, bit dropme);
    start_i = s;
    conf_i = c;
    pc_i = pc;
    eff_i = eff;
    st_i = st;
    if (dropme) drop_arm = 1;
    else model_event(c, pc, eff, st);
    tick();
    start_i = 0;
    conf_i = 0;
  endtask

  task automatic drain(bit rnd);
    int budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      tick();
      budget--;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    ready = 1;
    repeat (4) tick();
    chk("idle_pf_v", 64'(pf_v), 64'd0);
  endtask

  task automatic conf_first(logic [VA-1:0] pc, logic [VA-1:0] eff, logic [7:0] st, bit ev, logic [VA-1:0] ea);
    evt(0, 1, pc, eff, st, 0);
    repeat (3) tick();
    chk("first_pf_v", 64'(pf_v), 64'(ev));
    if (ev) chk("first_pf_addr", 64'(pf_addr), 64'(ea));
    drain(0);
  endtask

  task automatic do_reset();
    #2 reset_n_i = 0;
    m_reset();
    @(negedge clk) reset_n_i = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VA-1:0] pc, eff;
    logic [7:0] st;
    int kind;
    m_reset();
    #12;
    chk("rst_pf_v", 64'(pf_v), 64'd0);
    chk("rst_pf_addr", 64'(pf_addr), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    @(negedge clk) reset_n_i = 1;
    @(posedge clk);
    #1;
    // Basic confirm: exact latency, two prefetches, then quiet.
    evt(0, 1, 'h100, 'h8000, 8'h10, 0);
    chk("lat0", 64'(pf_v), 64'd0);
    tick();
    chk("lat1", 64'(pf_v), 64'd0);
    tick();
    chk("lat2", 64'(pf_v), 64'd0);
    tick();
    chk("lat3_v", 64'(pf_v), 64'd1);
    chk("lat3_addr", 64'(pf_addr), 64'h8010);
    tick();
    chk("second_v", 64'(pf_v), 64'd1);
    chk("second_addr", 64'(pf_addr), 64'h8020);
    tick();
    chk("after_deg_v", 64'(pf_v), 64'd0);
    // Negative stride crossing the page below.
    evt(0, 1, 'h200, 'h1008, 8'hF8, 0);
    repeat (3) tick();
    chk("neg_v", 64'(pf_v), 64'd1);
    chk("neg_addr", 64'(pf_addr), 64'h1000);
    tick();
    chk("page_cut_v", 64'(pf_v), 64'd0);
    drain(0);
    // Backpressure hold.
    ready = 0;
    evt(0, 1, 'h100, 'h8000, 8'h10, 0);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_v", 64'(pf_v), 64'd1);
      chk("hold_addr", 64'(pf_addr), 64'h8010);
      tick();
    end
    ready = 1;
    tick();
    chk("released_addr", 64'(pf_addr), 64'h8020);
    tick();
    chk("released_done", 64'(pf_v), 64'd0);
    // FIFO overflow while stalled.
    ready = 0;
    evt(0, 1, 'h300, 'h20000, 8'h40, 0);
    repeat (3) tick();
    chk("stall_addr", 64'(pf_addr), 64'h20040);
    evt(0, 1, 'h400, 'h30000, 8'h08, 0);
    evt(0, 1, 'h500, 'h40000, 8'h04, 0);
    evt(0, 1, 'h600, 'h50000, 8'h20, 1);
    drain(0);
    // Replacement order with five distinct PCs.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      evt(1, 0, VA'('hA00 + i * 'h100), VA'('h90000 + i * 'h1000), 8'h10, 0);
      drain(0);
    end
    conf_first('hB00, 'h50000, 8'h10, 1, 'h50010);
    conf_first('hA00, 'h60000, 8'h10, 1, 'h60010);
    conf_first('hB00, 'h50020, 8'h10, 1, 'h50030);
    conf_first('hB00, 'h50040, 8'h10, 0, '0);
    conf_first('hD00, 'h70000, 8'h00, 0, '0);
    // Asynchronous reset in the middle of ISSUE.
    ready = 0;
    evt(0, 1, 'h700, 'h70000, 8'h10, 0);
    repeat (3) tick();
    chk("pre_rst_v", 64'(pf_v), 64'd1);
    #2 reset_n_i = 0;
    #1;
    chk("async_rst_v", 64'(pf_v), 64'd0);
    chk("async_rst_addr", 64'(pf_addr), 64'd0);
    m_reset();
    @(negedge clk) reset_n_i = 1;
    @(posedge clk);
    #1;
    ready = 1;
    conf_first('h700, 'h70000, 8'h10, 1, 'h70010);
    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      for (int p = 0; p < (($urandom_range(3) == 0) ? 2 : 1); p++) begin
        pc = VA'(($urandom_range(5) + 1) * 256);
        eff = VA'({$urandom(), $urandom()});
        if ($urandom_range(2) == 0) eff[11:4] = 8'hFF;
        st = ($urandom_range(15) == 0) ? 8'h00 : 8'($urandom());
        for (int i = 0; i < NS; i++)
          if (m_v[i] && m_act[i] && m_pc[i] == longint'(pc) && $urandom_range(2) == 0) eff = VA'(m_last[i]);
        kind = int'($urandom_range(9));
        evt(kind < 3 || kind == 9, kind >= 3, pc, eff, st, 0);
      end
      drain(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
